// File: rtl/simd_pkg.sv
// Shared definitions for the 4-lane 12-bit SIMD adder datapath.
// Used by the operand packer, the SIMD adder wrapper and the result unpacker.
//   LANE_W  : width of one lane
//   LANES   : lanes per packed word
//   SIMD_W  : packed word width
//   CNT_W   : width of a lane index
//   state_t : packer FSM states
//   lane_lsb: bit position of lane k's LSB (lane 0 sits in the top bits)
package simd_pkg;
  localparam int LANE_W = 12;
  localparam int LANES  = 4;
  localparam int SIMD_W = LANE_W * LANES;
  localparam int CNT_W  = $clog2(LANES);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int lane_lsb(input int k);
    return SIMD_W - LANE_W * (k + 1);
  endfunction
endpackage

// File: rtl/simd_idle_timer.sv
// Idle timer: counts enabled cycles and pulses expired on the TIMEOUT-th one.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-low reset
//   enable  in  count this cycle
//   clear   in  return the count to zero (wins over enable)
//   expired out high during the TIMEOUT-th consecutive enabled cycle
// TIMEOUT = 0 disables expiry entirely.
module simd_idle_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    expired = 1'b0;
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      // Expiry is flagged while the last idle cycle is in progress, so the
      // owner acts on the same edge that would have completed the count.
      if ((TIMEOUT > 0) && (count_q == CW'(TIMEOUT - 1))) begin
        expired = 1'b1;
        count_d = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end
endmodule

// File: rtl/simd_add4_operand_packer.sv
// Packs scalar (a,b) operand pairs into LANES-wide words for the SIMD adder.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   in_valid/in_ready   scalar input handshake
//   in_a, in_b          scalar operands (LANE_W bits, passed bit-exact)
//   in_last             close the current group after this element
//   out_valid/out_ready packed output handshake
//   out_a, out_b        packed operands, lane 0 in the top bits
//   out_mask            out_mask[LANES-1-k] set when lane k carries data
// A group closes on its LANES-th element, on in_last, or after
// FLUSH_TIMEOUT idle cycles with at least one lane filled.
module simd_add4_operand_packer
  import simd_pkg::*;
#(
  parameter int FLUSH_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] in_a,
  input  logic [LANE_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIMD_W-1:0] out_a,
  output logic [SIMD_W-1:0] out_b,
  output logic [LANES-1:0]  out_mask
);
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SIMD_W-1:0]  buf_a_q, buf_a_d;
  logic [SIMD_W-1:0]  buf_b_q, buf_b_d;
  logic [LANES-1:0]   buf_mask_q, buf_mask_d;
  logic               out_valid_q, out_valid_d;
  logic [SIMD_W-1:0]  out_a_q, out_a_d;
  logic [SIMD_W-1:0]  out_b_q, out_b_d;
  logic [LANES-1:0]   out_mask_q, out_mask_d;

  logic accept, drain, slot_free, timer_en, expired;

  assign in_ready  = (state_q == FILL);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid_q & out_ready;
  assign slot_free = ~out_valid_q | out_ready;

  // Idle only counts while a partial group is open and nothing arrives.
  assign timer_en  = (state_q == FILL) && (cnt_q != '0) && !accept;

  simd_idle_timer #(
    .TIMEOUT(FLUSH_TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (timer_en),
    .clear  (!timer_en),
    .expired(expired)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_a_d     = buf_a_q;
    buf_b_d     = buf_b_q;
    buf_mask_d  = buf_mask_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_mask_d  = out_mask_q;

    if (drain) out_valid_d = 1'b0;

    case (state_q)
      FILL: begin
        if (accept) begin
          for (int k = 0; k < LANES; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              buf_a_d[lane_lsb(k) +: LANE_W] = in_a;
              buf_b_d[lane_lsb(k) +: LANE_W] = in_b;
              buf_mask_d[LANES-1-k]          = 1'b1;
            end
          end
          if ((cnt_q == CNT_W'(LANES - 1)) || in_last) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (expired) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        // Buffer lanes never written are still zero from the last clear.
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_a_d     = buf_a_q;
          out_b_d     = buf_b_q;
          out_mask_d  = buf_mask_q;
          buf_a_d     = '0;
          buf_b_d     = '0;
          buf_mask_d  = '0;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Group buffer -> output register boundary
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      buf_a_q     <= '0;
      buf_b_q     <= '0;
      buf_mask_q  <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_a_q     <= buf_a_d;
      buf_b_q     <= buf_b_d;
      buf_mask_q  <= buf_mask_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_mask_q  <= out_mask_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_mask  = out_mask_q;
endmodule
